// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, FSM encoding and the bit-period helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Integer division on purpose: the truncated period is what both ends agree on.
    function automatic int bit_cycles(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick every BIT_CYCLES clocks, re-phased by restart
// so each frame's bit edges are aligned to its load edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int clock_frequency = 12000000,
    parameter int baud_rate       = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int BIT_CYCLES = bit_cycles(clock_frequency, baud_rate);
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    generate
        if (BIT_CYCLES < 2) begin : g_bad_period
            $error("uart_baud_gen: clock_frequency/baud_rate must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(BIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-byte holding register so a queued
// byte's start bit follows the previous stop bit with no idle gap.
// Handshake: a byte is taken on any rising edge where valid && ready; the source
// keeps data_in/valid stable until then, and valid while ready=0 has no effect.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clock_frequency = 12000000,
    parameter int baud_rate       = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    generate
        if (STOP_BITS != 1) begin : g_bad_stop
            $error("uart_tx: only a single stop bit is implemented");
        end
    endgenerate

    uart_state_t state;
    logic [7:0]  hold;
    logic        hold_full;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        tick;
    logic        load;

    // A held byte moves to the shifter from IDLE, or straight off the end of a stop bit.
    assign load  = hold_full && ((state == IDLE) || ((state == STOP) && tick));
    assign ready = !hold_full;
    assign busy  = (state != IDLE) || hold_full;

    uart_baud_gen #(
        .clock_frequency(clock_frequency),
        .baud_rate      (baud_rate)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(load),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
        end else begin
            // Accept and load never coincide: load needs hold_full, accept needs ready.
            if (valid && ready) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (load) begin
                        shift   <= hold;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // tx is registered, so it takes the bit that becomes shift[0].
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (load) begin
                            shift   <= hold;
                            bit_idx <= '0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at a short bit period (80 kHz / 9600 -> 8 cycles,
// exercising the truncating division) so every scenario fits in a short run.
module tb_uart_tx;

    localparam int CLK_HZ = 80000;
    localparam int BAUD   = 9600;
    localparam int BC     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int passed = 0;

    uart_tx #(
        .clock_frequency(CLK_HZ),
        .baud_rate      (BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Samples one frame starting at the negedge of its first start-bit cycle.
    // bits[0] is the start bit, bits[8:1] the data, bits[9] the stop bit.
    task automatic capture_frame(output logic [9:0] bits, output int glitches,
                                 output logic busy_last);
        logic s;
        glitches  = 0;
        bits      = '0;
        busy_last = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BC; c++) begin
                s = tx;
                if (c == 0) bits[b] = s;
                else if (s !== bits[b]) glitches++;
                busy_last = busy;
                @(negedge clk);
            end
        end
    endtask

    // Independent mid-bit sampling receiver.
    task automatic rx_byte(output logic [7:0] d, output logic ferr, output logic timeout);
        int w;
        w = 0;
        d = '0;
        ferr = 1'b0;
        timeout = 1'b0;
        while (tx !== 1'b0 && w < 40 * BC) begin
            w++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        repeat (BC / 2) @(negedge clk);
        if (tx !== 1'b0) ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(negedge clk);
            d[i] = tx;
        end
        repeat (BC) @(negedge clk);
        if (tx !== 1'b1) ferr = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        data_in = b;
        valid   = 1'b1;
        while (ready !== 1'b1 && w < 40 * BC) begin
            w++;
            @(negedge clk);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset;
        int errs;
        errs  = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        data_in = '0;
        repeat (5) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) errs++;
        end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) errs++;
        end
        checks++;
        if (errs !== 0) $display("FAIL reset_idle: got %0d bad cycles want 0", errs);
        else passed++;
    endtask

    task automatic test_single;
        logic [9:0] f;
        int g;
        logic bl;
        data_in = 8'h55;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'h00;
        checks++;
        if (ready !== 1'b0) $display("FAIL single_ready_drop: got %b want 0", ready);
        else passed++;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_held: got tx=%b busy=%b want tx=1 busy=1", tx, busy);
        else passed++;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0 || ready !== 1'b1)
            $display("FAIL single_load: got tx=%b ready=%b want tx=0 ready=1", tx, ready);
        else passed++;
        capture_frame(f, g, bl);
        checks++;
        if (f !== {1'b1, 8'h55, 1'b0}) $display("FAIL single_frame: got %b want %b", f, {1'b1, 8'h55, 1'b0});
        else passed++;
        checks++;
        if (g !== 0 || bl !== 1'b1)
            $display("FAIL single_timing: got glitches=%0d busy_last=%b want 0 and 1", g, bl);
        else passed++;
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL single_idle_after: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [9:0] f1, f2, f3;
        int g1, g2, g3;
        logic b1, b2, b3;
        logic ready_after;
        int hold_cycles;
        @(negedge clk);
        data_in = 8'hA3;
        valid   = 1'b1;
        @(negedge clk);
        data_in = 8'h0F;
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) $display("FAIL b2b_first_start: got %b want 0", tx);
        else passed++;
        ready_after = 1'bx;
        hold_cycles = 0;
        fork
            begin
                capture_frame(f1, g1, b1);
                capture_frame(f2, g2, b2);
                capture_frame(f3, g3, b3);
            end
            begin
                @(negedge clk);
                ready_after = ready;
                data_in = 8'h12;
                while (ready !== 1'b1 && hold_cycles < 20 * BC) begin
                    hold_cycles++;
                    @(negedge clk);
                end
                @(negedge clk);
                valid   = 1'b0;
                data_in = 8'h77;
            end
        join
        checks++;
        if (ready_after !== 1'b0) $display("FAIL b2b_second_accept: got ready=%b want 0", ready_after);
        else passed++;
        checks++;
        if (hold_cycles !== 10 * BC - 1)
            $display("FAIL backpressure_hold: got %0d cycles want %0d", hold_cycles, 10 * BC - 1);
        else passed++;
        checks++;
        if (f1 !== {1'b1, 8'hA3, 1'b0}) $display("FAIL b2b_frame1: got %b want %b", f1, {1'b1, 8'hA3, 1'b0});
        else passed++;
        checks++;
        if (f2 !== {1'b1, 8'h0F, 1'b0}) $display("FAIL b2b_frame2: got %b want %b", f2, {1'b1, 8'h0F, 1'b0});
        else passed++;
        checks++;
        if (f3 !== {1'b1, 8'h12, 1'b0}) $display("FAIL backpressure_frame: got %b want %b", f3, {1'b1, 8'h12, 1'b0});
        else passed++;
        checks++;
        if (g1 + g2 + g3 !== 0) $display("FAIL b2b_bit_timing: got %0d glitches want 0", g1 + g2 + g3);
        else passed++;
        checks++;
        if (b1 !== 1'b1 || b2 !== 1'b1 || b3 !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b_total_length: got busy_last=%b%b%b busy_end=%b want 1110", b1, b2, b3, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] f;
        int g;
        logic bl;
        int low_cycles;
        @(negedge clk);
        data_in = 8'hFF;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        data_in = 8'h5A;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4 * BC + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0 || tx !== 1'b1)
            $display("FAIL midreset_pre: got busy=%b ready=%b tx=%b want 1 0 1", busy, ready, tx);
        else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midreset_abort: got tx=%b ready=%b busy=%b want 1 1 0", tx, ready, busy);
        else passed++;
        low_cycles = 0;
        repeat (12 * BC) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_cycles++;
        end
        checks++;
        if (low_cycles !== 0) $display("FAIL midreset_held_dropped: got %0d active cycles want 0", low_cycles);
        else passed++;
        data_in = 8'h81;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        capture_frame(f, g, bl);
        checks++;
        if (f !== {1'b1, 8'h81, 1'b0} || g !== 0)
            $display("FAIL midreset_next_frame: got %b glitches=%0d want %b 0", f, g, {1'b1, 8'h81, 1'b0});
        else passed++;
    endtask

    task automatic test_loopback;
        logic [7:0] exp_bytes [3];
        logic [7:0] got [3];
        logic ferr [3];
        logic tmo [3];
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        exp_bytes[2] = 8'h55;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 3; i++) send_byte(exp_bytes[i]);
            end
            begin
                for (int j = 0; j < 3; j++) rx_byte(got[j], ferr[j], tmo[j]);
            end
        join
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tmo[k] !== 1'b0 || ferr[k] !== 1'b0 || got[k] !== exp_bytes[k])
                $display("FAIL loopback_%0d: got %h ferr=%b timeout=%b want %h 0 0",
                         k, got[k], ferr[k], tmo[k], exp_bytes[k]);
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_reset_mid_frame;
        test_loopback;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing, LSB first. It is the transmit half of the serial link whose receive side the echo path already exercises. Bytes arrive from fabric logic (echo loop, NN result streamer) over a valid/ready handshake and are serialised onto the `tx` pin. A one-byte holding register lets back-to-back bytes go out with no idle gap between stop bit and next start bit.

Parameters:
- clock_frequency, 12000000, system clock frequency in Hz.
- baud_rate, 9600, line rate in bit/s. Bit period in cycles is BIT_CYCLES = clock_frequency/baud_rate, using integer division (1250 at the defaults). BIT_CYCLES must be at least 2; the implementation enforces this with an elaboration-time check.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- data_in  input  8  byte to transmit; sampled on the accept edge.
- valid  input  1  data_in is valid.
- ready  output  1  holding register is empty, so a byte can be accepted.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is on the line, or a byte is held waiting.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - tx=1, ready=1, busy=0.
  - FSM goes to IDLE, bit counter=0, cycle counter=0, holding register cleared.
  - Reset mid-frame aborts the frame: tx is 1 from the next edge, and any held byte is discarded.
- Accept: a byte is accepted on a rising edge where valid&&ready. Then:
  - data_in is latched into the holding register.
  - ready drops the following cycle.
  - valid while ready=0 is ignored; the source must hold data_in and valid stable until accepted.
- FSM states:
  - IDLE: tx=1. If the holding register is full, move it to the shift register, clear the holding register (ready=1 the next cycle) and go to START.
  - START: tx=0 for BIT_CYCLES cycles, then DATA.
  - DATA: tx=shift[0] for BIT_CYCLES cycles per bit, then shift right. Eight bits, index 0..7. After bit 7, go to STOP.
  - STOP: tx=1 for BIT_CYCLES cycles. At the end, if the holding register is full, load it and go straight to START (no idle cycle); otherwise go to IDLE.
- Latency: byte accepted at edge N with the FSM in IDLE:
  - the holding register is full after edge N;
  - the load happens at edge N+1, so tx=0 from edge N+1;
  - ready=1 again after edge N+1.
- Frame length: exactly 10*BIT_CYCLES cycles. Every bit lasts exactly BIT_CYCLES cycles, with no drift across a frame.
- Simultaneous events: a new accept and the shift-register load from the holding register in the same cycle is impossible, because the load happens only when the holding register is full, which means ready=0.
- Backpressure: at most one frame in flight plus one held byte.
  - During a frame, ready=1 until a second byte is accepted, then ready=0 until the STOP-to-START reload.
- busy = (state != IDLE) || holding register full.
- Cycle counter: counts 0..BIT_CYCLES-1. Its width is clog2(BIT_CYCLES) and it wraps to 0 at each bit boundary. Bit counter is 3 bits.
- tx is driven directly from a register, so it is glitch-free.

Decomposition:
- Package uart_pkg:
  - localparams DATA_BITS=8, STOP_BITS=1;
  - state encoding IDLE/START/DATA/STOP (2-bit);
  - BIT_CYCLES computation function, shared with the receiver.
- Sub-module uart_baud_gen:
  - parameterised by clock_frequency and baud_rate;
  - input `restart` (synchronous clear, asserted on frame load);
  - output `tick`, one cycle wide, every BIT_CYCLES cycles.
- The FSM advances on `tick`.

Test Plan:
1. Reset check: hold rst_n=0 for 5 cycles, then release -> tx=1, ready=1, busy=0 throughout and for 100 cycles afterwards.
2. Single byte 0x55 with defaults: valid for 1 cycle -> tx low exactly 1 cycle after accept, then bits 1,0,1,0,1,0,1,0. Each bit is 1250 cycles (start bit also 1250), stop bit high for 1250 cycles, and busy falls 12500 cycles after the load.
3. Back-to-back 0xA3 then 0x0F, valid held continuously:
   - second accept lands during the first frame, after which ready=0;
   - the second start bit begins on the cycle immediately after the first stop bit ends;
   - total 25000 cycles from first load to idle.
4. Backpressure: hold valid with data 0x12 while ready=0 -> no third byte is accepted until the reload; the byte on the line equals the value present at the accept edge.
5. Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF -> tx=1 from the next edge, ready=1, the held byte is dropped, and the next byte 0x81 is transmitted correctly.
6. Loopback: connect tx to the echo receiver at 9600 baud and send 0x00, 0xFF, 0x55 -> the receiver reports identical bytes and no framing errors.
